// File: rtl/apu_pkg.sv
// Shared APU definitions: duty width, default counter width and the
// measurement FSM state encoding used by the PWM duty capture block.
package apu_pkg;

  localparam int DUTY_W    = 8;
  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    WAIT_RISE = 1'b0,
    MEASURE   = 1'b1
  } meas_state_e;

endpackage

// File: rtl/pwm_duty_div.sv
// Sequential restoring divider: floor({dividend_hi, 8'b0} / divisor),
// one quotient bit per cycle, busy for nine cycles after start.
module pwm_duty_div
  import apu_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_dividend_hi,
  input  logic [CNT_W-1:0]  i_divisor,
  output logic              o_busy,
  output logic              o_done,
  output logic [DUTY_W-1:0] o_quotient
);

  logic [CNT_W:0]      r_rem;
  logic [CNT_W-1:0]    r_div;
  logic [DUTY_W-1:0]   r_q;
  logic [3:0]          r_cnt;
  logic                r_sat;

  logic [CNT_W:0]      w_shift;
  logic [CNT_W:0]      w_sub;
  logic                w_ge;
  logic [DUTY_W-1:0]   w_q_next;

  // The remainder's carry bit means the shifted value already exceeds any divisor.
  assign w_shift  = {r_rem[CNT_W-1:0], 1'b0};
  assign w_ge     = r_rem[CNT_W] | (w_shift >= {1'b0, r_div});
  assign w_sub    = w_shift - {1'b0, r_div};
  assign w_q_next = {r_q[DUTY_W-2:0], w_ge};

  assign o_busy     = (r_cnt != 4'd0);
  // done flags the final iteration so the caller can register the result in the same edge
  assign o_done     = (r_cnt == 4'd2);
  assign o_quotient = r_sat ? {DUTY_W{1'b1}} : w_q_next;

  // Load on start, iterate for eight cycles, then one trailing busy cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rem <= {(CNT_W+1){1'b0}};
      r_div <= {CNT_W{1'b0}};
      r_q   <= {DUTY_W{1'b0}};
      r_cnt <= 4'd0;
      r_sat <= 1'b0;
    end else if (i_start && !o_busy) begin
      r_rem <= {1'b0, i_dividend_hi};
      r_div <= i_divisor;
      r_q   <= {DUTY_W{1'b0}};
      r_cnt <= 4'd9;
      r_sat <= (i_divisor == {CNT_W{1'b0}}) || (i_dividend_hi >= i_divisor);
    end else if (r_cnt >= 4'd2) begin
      r_rem <= w_ge ? w_sub : w_shift;
      r_q   <= w_q_next;
      r_cnt <= r_cnt - 4'd1;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end else begin
      r_cnt <= 4'd0;
    end
  end

endmodule

// File: rtl/pwm_duty_capture.sv
// PWM period / high-time / duty meter with stuck-line timeout and overrun
// reporting; receive-side counterpart of the APU buzzer generator.
module pwm_duty_capture
  import apu_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pwm_in,
  output logic              sample_valid,
  output logic [CNT_W-1:0]  period_cnt,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [DUTY_W-1:0] duty,
  output logic              stuck,
  output logic              stuck_level,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic              r_sync1, r_sync2, r_sync3, r_rise;
  meas_state_e       r_state;
  logic [CNT_W-1:0]  r_per_c, r_hi_c, r_p, r_h;
  logic              r_sample_valid, r_stuck, r_stuck_level, r_overrun;
  logic [CNT_W-1:0]  r_period, r_high;
  logic [DUTY_W-1:0] r_duty;

  logic              w_level;
  logic [CNT_W:0]    w_per_p1;
  logic [CNT_W-1:0]  w_p;
  logic [CNT_W-1:0]  w_hi_inc;
  logic              w_start;
  logic              w_div_busy, w_div_done;
  logic [DUTY_W-1:0] w_quot;

  // r_sync3 is the level aligned with the registered rise strobe (cycle R).
  assign w_level  = r_sync3;
  assign w_per_p1 = {1'b0, r_per_c} + {1'b0, CNT_ONE};
  assign w_p      = w_per_p1[CNT_W] ? CNT_MAX : w_per_p1[CNT_W-1:0];
  assign w_hi_inc = (r_hi_c == CNT_MAX) ? r_hi_c : r_hi_c + {{(CNT_W-1){1'b0}}, w_level};
  assign w_start  = (r_state == MEASURE) && r_rise && !w_div_busy;

  pwm_duty_div #(.CNT_W(CNT_W)) u_div (
    .clk           (clk),
    .rstn          (rstn),
    .i_start       (w_start),
    .i_dividend_hi (r_hi_c),
    .i_divisor     (w_p),
    .o_busy        (w_div_busy),
    .o_done        (w_div_done),
    .o_quotient    (w_quot)
  );

  // Synchronizer, edge detect, measurement FSM, counters and result registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sync1        <= 1'b0;
      r_sync2        <= 1'b0;
      r_sync3        <= 1'b0;
      r_rise         <= 1'b0;
      r_state        <= WAIT_RISE;
      r_per_c        <= CNT_ZERO;
      r_hi_c         <= CNT_ZERO;
      r_p            <= CNT_ZERO;
      r_h            <= CNT_ZERO;
      r_sample_valid <= 1'b0;
      r_stuck        <= 1'b0;
      r_stuck_level  <= 1'b0;
      r_overrun      <= 1'b0;
      r_period       <= CNT_ZERO;
      r_high         <= CNT_ZERO;
      r_duty         <= {DUTY_W{1'b0}};
    end else begin
      r_sync1        <= pwm_in;
      r_sync2        <= r_sync1;
      r_sync3        <= r_sync2;
      r_rise         <= r_sync2 & ~r_sync3;
      r_sample_valid <= 1'b0;
      r_overrun      <= 1'b0;

      case (r_state)
        WAIT_RISE: begin
          r_per_c <= CNT_ZERO;
          if (r_rise) begin
            r_state <= MEASURE;
            r_stuck <= 1'b0;
            r_hi_c  <= {{(CNT_W-1){1'b0}}, w_level};
          end else begin
            r_hi_c  <= CNT_ZERO;
          end
        end
        MEASURE: begin
          // The edge cycle itself is the first cycle of the next window.
          if (r_rise) begin
            if (w_div_busy) begin
              r_overrun <= 1'b1;
            end else begin
              r_p <= w_p;
              r_h <= r_hi_c;
            end
            r_per_c <= CNT_ZERO;
            r_hi_c  <= {{(CNT_W-1){1'b0}}, w_level};
          end else if (r_per_c >= TIMEOUT_C) begin
            r_stuck        <= 1'b1;
            r_stuck_level  <= w_level;
            r_duty         <= w_level ? {DUTY_W{1'b1}} : {DUTY_W{1'b0}};
            r_sample_valid <= 1'b1;
            r_state        <= WAIT_RISE;
            r_per_c        <= CNT_ZERO;
            r_hi_c         <= CNT_ZERO;
          end else begin
            r_per_c <= r_per_c + CNT_ONE;
            r_hi_c  <= w_hi_inc;
          end
        end
        default: begin
          r_state <= WAIT_RISE;
          r_per_c <= CNT_ZERO;
          r_hi_c  <= CNT_ZERO;
        end
      endcase

      if (w_div_done) begin
        r_period       <= r_p;
        r_high         <= r_h;
        r_duty         <= w_quot;
        r_sample_valid <= 1'b1;
      end
    end
  end

  assign sample_valid = r_sample_valid;
  assign period_cnt   = r_period;
  assign high_cnt     = r_high;
  assign duty         = r_duty;
  assign stuck        = r_stuck;
  assign stuck_level  = r_stuck_level;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Scoreboard bench for pwm_duty_capture: stimulus pushes expected samples
// and overrun pulses, a monitor pops and compares on every DUT strobe.
module tb_pwm_duty_capture;

  localparam int CW = 16;
  localparam int TO = 1000;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          pwm_in = 1'b0;
  logic          sample_valid;
  logic [CW-1:0] period_cnt;
  logic [CW-1:0] high_cnt;
  logic [7:0]    duty;
  logic          stuck;
  logic          stuck_level;
  logic          overrun;

  pwm_duty_capture #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .pwm_in       (pwm_in),
    .sample_valid (sample_valid),
    .period_cnt   (period_cnt),
    .high_cnt     (high_cnt),
    .duty         (duty),
    .stuck        (stuck),
    .stuck_level  (stuck_level),
    .overrun      (overrun)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int at;
    int per;
    int hi;
    int dut_y;
    int stk;
    int lvl;
  } exp_t;

  exp_t sq[$];
  int   oq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest expected entry.
  initial begin
    exp_t e;
    int   o;
    forever begin
      @(negedge clk);
      if (sample_valid) begin
        n_vec++;
        if (sq.size() == 0) begin
          n_bad++;
          $display("FAIL sample_unexpected: got sample at cycle %0d per=%0d hi=%0d duty=%0d stuck=%0d, required none",
                   cyc, period_cnt, high_cnt, duty, stuck);
        end else begin
          e = sq.pop_front();
          if (cyc != e.at || int'(period_cnt) != e.per || int'(high_cnt) != e.hi ||
              int'(duty) != e.dut_y || int'(stuck) != e.stk || int'(stuck_level) != e.lvl) begin
            n_bad++;
            $display("FAIL sample: got cyc=%0d per=%0d hi=%0d duty=%0d stuck=%0d lvl=%0d, required cyc=%0d per=%0d hi=%0d duty=%0d stuck=%0d lvl=%0d",
                     cyc, period_cnt, high_cnt, duty, stuck, stuck_level,
                     e.at, e.per, e.hi, e.dut_y, e.stk, e.lvl);
          end
        end
      end
      if (overrun) begin
        n_vec++;
        if (oq.size() == 0) begin
          n_bad++;
          $display("FAIL overrun_unexpected: got pulse at cycle %0d, required none", cyc);
        end else begin
          o = oq.pop_front();
          if (cyc != o) begin
            n_bad++;
            $display("FAIL overrun: got pulse at cycle %0d, required cycle %0d", cyc, o);
          end
        end
      end
    end
  end

  task automatic do_reset();
    pwm_in = 1'b0;
    rstn   = 1'b0;
    repeat (3) @(negedge clk);
    rstn   = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // n periods of hi/lo; each rise after the first closes a window.
  task automatic burst(input int hi, input int lo, input int n, input int exp_duty,
                       output int last_rise);
    last_rise = 0;
    for (int k = 0; k < n; k++) begin
      pwm_in = 1'b1;
      if (k > 0) sq.push_back('{cyc + 12, hi + lo, hi, exp_duty, 0, 0});
      last_rise = cyc;
      repeat (hi) @(negedge clk);
      pwm_in = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  initial begin
    int r;
    @(negedge clk);
    rstn   = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_period_cnt",   period_cnt,   0);
    chk("rst_high_cnt",     high_cnt,     0);
    chk("rst_duty",         duty,         0);
    chk("rst_stuck",        stuck,        0);
    chk("rst_stuck_level",  stuck_level,  0);
    chk("rst_overrun",      overrun,      0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // Buzzer-like 100/156: first rise only opens the window.
    burst(100, 156, 4, 100, r);

    // Next rise starts a division; reset lands at R+4 and aborts it.
    pwm_in = 1'b1;
    r = cyc;
    repeat (7) @(negedge clk);
    rstn   = 1'b0;
    pwm_in = 1'b0;
    @(negedge clk);
    chk("midrst_sample_valid", sample_valid, 0);
    chk("midrst_period_cnt",   period_cnt,   0);
    chk("midrst_high_cnt",     high_cnt,     0);
    chk("midrst_duty",         duty,         0);
    chk("midrst_overrun",      overrun,      0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    burst(100, 156, 3, 100, r);
    do_reset();

    // 128/72 then hold low: timeout keeps the last period/high values.
    burst(128, 72, 3, 163, r);
    sq.push_back('{r + 1005, 200, 128, 0, 1, 0});
    while (cyc < r + 1010) @(negedge clk);
    chk("stuck_set",   stuck,       1);
    chk("stuck_level", stuck_level, 0);
    burst(50, 50, 3, 128, r);
    chk("stuck_cleared", stuck, 0);
    do_reset();

    // Period 6: third rise hits a busy divider.
    r = cyc;
    sq.push_back('{r + 18, 6, 3, 128, 0, 0});
    oq.push_back(r + 16);
    sq.push_back('{r + 30, 6, 3, 128, 0, 0});
    repeat (4) begin
      pwm_in = 1'b1;
      repeat (3) @(negedge clk);
      pwm_in = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    do_reset();

    // Rise coincides with the counter reaching the timeout: rise wins.
    r = cyc;
    pwm_in = 1'b1;
    repeat (10) @(negedge clk);
    pwm_in = 1'b0;
    while (cyc < r + 1001) @(negedge clk);
    pwm_in = 1'b1;
    sq.push_back('{cyc + 12, 1001, 10, 2, 0, 0});
    repeat (10) @(negedge clk);
    pwm_in = 1'b0;
    repeat (30) @(negedge clk);
    chk("coincide_no_stuck", stuck, 0);

    chk("samples_outstanding",  sq.size(), 0);
    chk("overruns_outstanding", oq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
